hawk_sector_deserializer: RTL and testbench

HAWK_SECTOR_DESERIALIZER -- requirements
Module: hawk_sector_deserializer

---
 rtl/hawk_pkg.sv | 27 ++
 rtl/hawk_word_fifo2.sv | 69 ++++++
 rtl/hawk_sector_deserializer.sv | 230 +++++++++++++++++++++++
 tb/tb_hawk_sector_deserializer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hawk_pkg.sv
// ---------------------------------------------------------------------------
// hawk_pkg -- shared definitions for the Hawk sector deserializer.
//
// Contents:
//   WORD_W   : width of an assembled data word (16 bits).
//   CKSUM_W  : width of the sector checksum accumulator (16 bits).
//   state_e  : deserializer FSM state encoding.
//
// Configuration macro: HAWK_DESER_CHECKSUM_EN adds the CKSUM state.
// ---------------------------------------------------------------------------
package hawk_pkg;

  localparam int WORD_W  = 16;
  localparam int CKSUM_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HUNT  = 3'd1,
    ST_ARMED = 3'd2,
    ST_DATA  = 3'd3
`ifdef HAWK_DESER_CHECKSUM_EN
    ,
    ST_CKSUM = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/hawk_word_fifo2.sv
// ---------------------------------------------------------------------------
// hawk_word_fifo2 -- two-entry first-in first-out word buffer.
//
// The head word is always held in entry 0, so data_o only changes when the
// head is popped (or when a word lands in an empty buffer).
//
// Ports:
//   hf_clk       : clock, posedge
//   rst          : synchronous active-high reset (buffer empty, data_o = 0)
//   push_i       : write push_data_i (ignored when full with no pop)
//   push_data_i  : word to write
//   pop_i        : remove the head word (ignored when empty)
//   full_o       : both entries occupied
//   empty_o      : no entries occupied
//   data_o       : head-of-buffer word
// ---------------------------------------------------------------------------
module hawk_word_fifo2
  import hawk_pkg::*;
(
  input  logic              hf_clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [WORD_W-1:0] data_o
);

  logic [WORD_W-1:0] head_q;
  logic [WORD_W-1:0] tail_q;
  logic [1:0]        cnt_q;
  logic              do_pop;
  logic              do_push;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign data_o  = head_q;

  // A pop frees a slot in the same cycle, so a full buffer can still accept.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge hf_clk) begin
    if (rst) begin
      // NOTE: both storage entries are reset, not just the count, so the
      // head word reads as zero out of reset instead of an unknown value.
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      // NOTE: every state register here uses <= so all of them update from
      // the same pre-edge values regardless of statement order.
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
      if (do_pop) begin
        if (cnt_q == 2'd2) begin
          head_q <= tail_q;
          if (do_push) tail_q <= push_data_i;
        end else if (do_push) begin
          head_q <= push_data_i;
        end
      end else if (do_push) begin
        if (cnt_q == 2'd0) head_q <= push_data_i;
        else               tail_q <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/hawk_sector_deserializer.sv
// ---------------------------------------------------------------------------
// hawk_sector_deserializer -- turns the bit stream from a disk data separator
// into 16-bit sector words.
//
// A sector is a run of at least PREAMBLE_MIN zeros, a single 1 (sync bit),
// SECTOR_WORDS data words sent MSB first and, optionally, a 16-bit checksum
// word equal to the modulo-2^16 sum of the data words.
//
// Parameters:
//   PREAMBLE_MIN : consecutive zeros needed before a sync bit is accepted
//   SECTOR_WORDS : data words per sector (checksum word not included)
//
// Ports:
//   hf_clk       : clock, posedge
//   rst          : synchronous active-high reset
//   en           : enable; low returns the FSM to IDLE on the next edge
//   wr_clock     : one-cycle bit strobe
//   wr_data      : bit value, valid with wr_clock
//   word_data    : head-of-buffer word
//   word_valid   : buffer non-empty
//   word_ready   : consumer accepts word_data when word_valid is also high
//   sector_start : one-cycle pulse after the sync bit
//   sector_done  : one-cycle pulse after the last word of a sector
//   overrun      : sticky, a word was dropped on a full buffer
//   cksum_err    : sticky, checksum mismatch (0 when checksum disabled)
//
// Configuration macro: HAWK_DESER_CHECKSUM_EN enables the checksum word.
// ---------------------------------------------------------------------------
module hawk_sector_deserializer
  import hawk_pkg::*;
#(
  parameter int PREAMBLE_MIN = 32,
  parameter int SECTOR_WORDS = 256
) (
  input  logic              hf_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_clock,
  input  logic              wr_data,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              sector_start,
  output logic              sector_done,
  output logic              overrun,
  output logic              cksum_err
);

  localparam int ZC_W = $clog2(PREAMBLE_MIN + 1);
  localparam int WC_W = $clog2(SECTOR_WORDS + 1);

  state_e              state_q, state_d;
  logic [ZC_W-1:0]     zero_cnt_q, zero_cnt_d;
  logic [ZC_W-1:0]     zero_inc;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
  // Only 15 bits are stored: the 16th arrives with the strobe that
  // completes the word, so the full word is formed combinationally.
  logic [WORD_W-2:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   shift_next;
  logic                last_bit;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;
`ifdef HAWK_DESER_CHECKSUM_EN
  logic [CKSUM_W-1:0]  acc_q, acc_d;
  logic                cksum_err_q, cksum_err_d;
`endif

  assign shift_next = {shift_q, wr_data};
  assign last_bit   = (bit_cnt_q == 4'hF);
  assign zero_inc   = (zero_cnt_q == ZC_W'(PREAMBLE_MIN)) ? zero_cnt_q
                                                          : zero_cnt_q + ZC_W'(1);

  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    zero_cnt_d = zero_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    push       = 1'b0;
`ifdef HAWK_DESER_CHECKSUM_EN
    acc_d       = acc_q;
    cksum_err_d = cksum_err_q;
`endif

    if (!en) begin
      // Any partial word is simply abandoned; buffered words stay put.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_HUNT;
          zero_cnt_d = '0;
        end

        ST_HUNT: begin
          if (wr_clock) begin
            if (wr_data) begin
              zero_cnt_d = '0;
            end else begin
              zero_cnt_d = zero_inc;
              if (zero_inc == ZC_W'(PREAMBLE_MIN)) state_d = ST_ARMED;
            end
          end
        end

        ST_ARMED: begin
          if (wr_clock && wr_data) begin
            state_d    = ST_DATA;
            start_d    = 1'b1;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            shift_d    = '0;
            overrun_d  = 1'b0;
`ifdef HAWK_DESER_CHECKSUM_EN
            acc_d       = '0;
            cksum_err_d = 1'b0;
`endif
          end
        end

        ST_DATA: begin
          if (wr_clock) begin
            shift_d   = shift_next[WORD_W-2:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              push       = 1'b1;
              word_cnt_d = word_cnt_q + WC_W'(1);
`ifdef HAWK_DESER_CHECKSUM_EN
              // Dropped words are still summed: the sender's checksum
              // covers every word it sent, not just those we kept.
              acc_d = acc_q + shift_next;
`endif
              if (word_cnt_q == WC_W'(SECTOR_WORDS - 1)) begin
`ifdef HAWK_DESER_CHECKSUM_EN
                state_d = ST_CKSUM;
`else
                state_d    = ST_HUNT;
                zero_cnt_d = '0;
                done_d     = 1'b1;
`endif
              end
            end
          end
        end

`ifdef HAWK_DESER_CHECKSUM_EN
        ST_CKSUM: begin
          if (wr_clock) begin
            shift_d   = shift_next[WORD_W-2:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              if (shift_next != acc_q) cksum_err_d = 1'b1;
              done_d     = 1'b1;
              state_d    = ST_HUNT;
              zero_cnt_d = '0;
            end
          end
        end
`endif

        default: state_d = ST_IDLE;
      endcase
    end

    // A full buffer only drops the word if the head is not leaving this cycle.
    if (push && fifo_full && !word_ready) overrun_d = 1'b1;
  end

  always_ff @(posedge hf_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      zero_cnt_q <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef HAWK_DESER_CHECKSUM_EN
      acc_q       <= '0;
      cksum_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      start_q    <= start_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
`ifdef HAWK_DESER_CHECKSUM_EN
      acc_q       <= acc_d;
      cksum_err_q <= cksum_err_d;
`endif
    end
  end

  hawk_word_fifo2 u_fifo (
    .hf_clk      (hf_clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (shift_next),
    .pop_i       (word_ready),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .data_o      (word_data)
  );

  assign word_valid   = !fifo_empty;
  assign sector_start = start_q;
  assign sector_done  = done_q;
  assign overrun      = overrun_q;
`ifdef HAWK_DESER_CHECKSUM_EN
  assign cksum_err = cksum_err_q;
`else
  assign cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_hawk_sector_deserializer.sv
// ---------------------------------------------------------------------------
// tb_hawk_sector_deserializer -- scoreboard bench for the sector deserializer.
// Stimulus builds sector bit streams from word lists; expected words go into
// a queue that a separate monitor drains whenever the DUT hands a word over.
// ---------------------------------------------------------------------------
module tb_hawk_sector_deserializer;

  localparam int PMIN = 32;
  localparam int SW   = 2;
`ifdef HAWK_DESER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        hf_clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wr_clock;
  logic        wr_data;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        sector_start;
  logic        sector_done;
  logic        overrun;
  logic        cksum_err;

  int          checks = 0;
  int          fails  = 0;
  logic [15:0] exp_q[$];
  int          n_start = 0;
  int          n_done  = 0;
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: never

  always #5 hf_clk = ~hf_clk;

  hawk_sector_deserializer #(
    .PREAMBLE_MIN (PMIN),
    .SECTOR_WORDS (SW)
  ) dut (
    .hf_clk       (hf_clk),
    .rst          (rst),
    .en           (en),
    .wr_clock     (wr_clock),
    .wr_data      (wr_data),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .sector_start (sector_start),
    .sector_done  (sector_done),
    .overrun      (overrun),
    .cksum_err    (cksum_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counting and scoreboard comparison, away from the edge.
  initial begin
    forever begin
      @(negedge hf_clk);
      if (!rst) begin
        if (sector_start) n_start++;
        if (sector_done)  n_done++;
        if (word_valid && word_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word", word_data);
          end else begin
            check("word", word_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  // Consumer: in random mode it never stalls more than 3 cycles in a row, so
  // a word arriving every >= 16 cycles can never find the buffer full.
  initial begin
    int idle_run = 0;
    word_ready = 1'b0;
    forever begin
      @(posedge hf_clk);
      #1;
      case (ready_mode)
        0: word_ready = 1'b1;
        2: word_ready = 1'b0;
        default: begin
          if (idle_run >= 3 || ($urandom % 2) == 1) begin
            word_ready = 1'b1;
            idle_run   = 0;
          end else begin
            word_ready = 1'b0;
            idle_run++;
          end
        end
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge hf_clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) idle($urandom_range(0, 2));
    wr_clock = 1'b1;
    wr_data  = b;
    @(posedge hf_clk);
    #1;
    wr_clock = 1'b0;
    wr_data  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit gaps);
    for (int i = 15; i >= 0; i--) send_bit(w[i], gaps);
  endtask

  task automatic send_zeros(input int n, input bit gaps);
    for (int i = 0; i < n; i++) send_bit(1'b0, gaps);
  endtask

  // Words plus (when enabled) the checksum word; expected words queued first.
  task automatic send_body(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] ck, input bit gaps, input bit expect_words);
    if (expect_words) begin
      exp_q.push_back(w0);
      exp_q.push_back(w1);
    end
    send_word(w0, gaps);
    send_word(w1, gaps);
    if (CK_EN) send_word(ck, gaps);
  endtask

  task automatic send_sector(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] ck, input bit gaps, input bit expect_words);
    send_zeros(PMIN, gaps);
    send_bit(1'b1, gaps);
    send_body(w0, w1, ck, gaps, expect_words);
  endtask

  function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = (int'(a) + int'(b)) % 65536;
    return s[15:0];
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   word_valid,   1'b0);
    check({tag, "_data"},    word_data,    16'h0000);
    check({tag, "_start"},   sector_start, 1'b0);
    check({tag, "_done"},    sector_done,  1'b0);
    check({tag, "_overrun"}, overrun,      1'b0);
    check({tag, "_ckerr"},   cksum_err,    1'b0);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    rst = 1'b1; en = 1'b0; wr_clock = 1'b0; wr_data = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic sector, ready always high, with first-word latency check.
    ready_mode = 0;
    en = 1'b1;
    idle(3);
    n_start = 0; n_done = 0;
    send_zeros(PMIN, 1'b0);
    send_bit(1'b1, 1'b0);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hFFFF);
    send_word(16'h1234, 1'b0);
    check("latency_valid", word_valid, 1'b1);
    check("latency_data",  word_data,  16'h1234);
    send_word(16'hFFFF, 1'b0);
    if (CK_EN) send_word(model_sum(16'h1234, 16'hFFFF), 1'b0);
    idle(3);
    check("basic_starts", n_start, 1);
    check("basic_dones",  n_done,  1);
    check("basic_ckerr",  cksum_err, 1'b0);
    check("basic_overrun", overrun, 1'b0);
    wait_drain("basic_drain");

    // Bad checksum: flag holds through HUNT, clears at the next sync.
    send_sector(16'h1234, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    idle(3);
    check("badck_err", cksum_err, CK_EN);
    send_zeros(10, 1'b0);
    check("badck_hold_hunt", cksum_err, CK_EN);
    send_zeros(PMIN, 1'b0);
    send_bit(1'b1, 1'b0);
    check("badck_clear_on_sync", cksum_err, 1'b0);
    send_body(16'h0F0F, 16'hF0F0, model_sum(16'h0F0F, 16'hF0F0), 1'b0, 1'b1);
    idle(3);
    check("goodck_err", cksum_err, 1'b0);
    wait_drain("badck_drain");

    // A 1 after 31 zeros must not count as sync.
    n_start = 0; n_done = 0;
    send_zeros(PMIN - 1, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(2);
    check("short_pre_no_start", n_start, 0);
    send_sector(16'hA5A5, 16'h5A5A, model_sum(16'hA5A5, 16'h5A5A), 1'b0, 1'b1);
    idle(3);
    check("short_pre_one_start", n_start, 1);
    wait_drain("short_pre_drain");

    // Randomized sectors with irregular strobes and a stalling consumer.
    ready_mode = 1;
    n_start = 0; n_done = 0;
    for (int s = 0; s < 6; s++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      send_sector(a, b, model_sum(a, b), 1'b1, 1'b1);
    end
    idle(3);
    check("rand_starts",  n_start, 6);
    check("rand_dones",   n_done,  6);
    check("rand_ckerr",   cksum_err, 1'b0);
    check("rand_overrun", overrun, 1'b0);
    wait_drain("rand_drain");

    // Overrun: no pops for four words; the first two survive in order.
    ready_mode = 2;
    idle(3);
    send_sector(16'h1111, 16'h2222, model_sum(16'h1111, 16'h2222), 1'b0, 1'b1);
    send_sector(16'h3333, 16'h4444, model_sum(16'h3333, 16'h4444), 1'b0, 1'b0);
    idle(3);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_head", word_data, 16'h1111);
    idle(5);
    check("ovr_head_stable", word_data, 16'h1111);
    ready_mode = 0;
    wait_drain("ovr_drain");
    idle(2);
    check("ovr_empty_after", word_valid, 1'b0);

    // en dropped mid-word: nothing pushed, no done, strobes ignored while low.
    n_start = 0; n_done = 0;
    send_zeros(PMIN, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 15; i >= 8; i--) send_bit(i[0], 1'b0);
    en = 1'b0;
    idle(4);
    check("endrop_no_done",  n_done, 0);
    check("endrop_no_word",  word_valid, 1'b0);
    check("endrop_one_start", n_start, 1);
    send_zeros(PMIN + 8, 1'b0);
    send_bit(1'b1, 1'b0);
    send_word(16'hABCD, 1'b0);
    idle(2);
    check("en_low_ignored_start", n_start, 1);
    check("en_low_ignored_word",  word_valid, 1'b0);
    en = 1'b1;
    idle(2);
    send_word(16'h5555, 1'b0);
    idle(2);
    check("reenable_no_false_sync", n_start, 1);
    send_sector(16'hBEEF, 16'hCAFE, model_sum(16'hBEEF, 16'hCAFE), 1'b0, 1'b1);
    idle(3);
    check("reenable_starts", n_start, 2);
    check("reenable_dones",  n_done,  1);
    wait_drain("reenable_drain");

    // Reset mid-word with one word buffered.
    ready_mode = 2;
    idle(3);
    send_zeros(PMIN, 1'b0);
    send_bit(1'b1, 1'b0);
    send_word(16'h7E57, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check("prerst_valid", word_valid, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    idle(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    ready_mode = 0;
    idle(3);
    n_start = 0; n_done = 0;
    send_sector(16'h0001, 16'h8000, model_sum(16'h0001, 16'h8000), 1'b0, 1'b1);
    idle(3);
    check("postrst_starts", n_start, 1);
    check("postrst_dones",  n_done,  1);
    wait_drain("postrst_drain");

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
